// File: rtl/log_encode_seq.sv
// Sequential log2 front end for the 8-bit logarithmic multiplier.
// Normalises two operands by left shifts to produce characteristic, Mitchell mantissa and zero flag.
module log_encode_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] n_var_1,
    input  logic [7:0] n_var_2,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic [6:0] xm,
    output logic [6:0] ym,
    output logic       xz,
    output logic       yz,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] ra_q, ra_d;
    logic [7:0] rb_q, rb_d;
    logic [3:0] ca_q, ca_d;
    logic [3:0] cb_q, cb_d;
    logic       za_q, za_d;
    logic       zb_q, zb_d;

    logic       fin_a;
    logic       fin_b;

    // A zero operand never reaches a leading one, so its flag counts as finished.
    assign fin_a = ra_q[7] | za_q;
    assign fin_b = rb_q[7] | zb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ra_q    <= 8'd0;
            rb_q    <= 8'd0;
            ca_q    <= 4'd0;
            cb_q    <= 4'd0;
            za_q    <= 1'b0;
            zb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            za_q    <= za_d;
            zb_q    <= zb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        za_d    = za_q;
        zb_d    = zb_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    ra_d    = n_var_1;
                    rb_d    = n_var_2;
                    ca_d    = 4'd7;
                    cb_d    = 4'd7;
                    za_d    = (n_var_1 == 8'd0);
                    zb_d    = (n_var_2 == 8'd0);
                    state_d = StShift;
                end
            end
            StShift: begin
                if (fin_a && fin_b) begin
                    state_d = StDone;
                end else begin
                    if (!fin_a) begin
                        ra_d = {ra_q[6:0], 1'b0};
                        ca_d = ca_q - 4'd1;
                    end
                    if (!fin_b) begin
                        rb_d = {rb_q[6:0], 1'b0};
                        cb_d = cb_q - 4'd1;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StShift);

    // The characteristic register of a zero operand still holds 7; report 0 instead.
    assign x  = za_q ? 4'd0 : ca_q;
    assign y  = zb_q ? 4'd0 : cb_q;
    assign xm = ra_q[6:0];
    assign ym = rb_q[6:0];
    assign xz = za_q;
    assign yz = zb_q;

    a_x_range : assert property (@(posedge clk) disable iff (rst) out_valid |-> (x[3] == 1'b0));
    a_y_range : assert property (@(posedge clk) disable iff (rst) out_valid |-> (y[3] == 1'b0));
    a_one_hot : assert property (@(posedge clk) disable iff (rst)
                                 $onehot({in_ready, busy, out_valid}));

endmodule

// File: tb/tb_log_encode_seq.sv
// Self-checking bench for log_encode_seq: transaction-level model, every-cycle compare,
// directed literal cases and randomized traffic with occasional resets.
module tb_log_encode_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] n_var_1;
    logic [7:0] n_var_2;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] x;
    logic [3:0] y;
    logic [6:0] xm;
    logic [6:0] ym;
    logic       xz;
    logic       yz;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    log_encode_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n_var_1   (n_var_1),
        .n_var_2   (n_var_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .xm        (xm),
        .ym        (ym),
        .xz        (xz),
        .yz        (yz),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference arithmetic: floor(log2(v)), with 0 for v == 0.
    function automatic int char_of(input int v);
        int c = 0;
        for (int i = 0; i < 8; i++) if (((v >> i) & 1) != 0) c = i;
        return c;
    endfunction

    function automatic int mant_of(input int v);
        if (v == 0) return 0;
        return (v << (7 - char_of(v))) & 8'h7F;
    endfunction

    function automatic int lz_of(input int v);
        if (v == 0) return 0;
        return 7 - char_of(v);
    endfunction

    // Transaction-level model: idle / counting down latency / holding result.
    bit m_idle, m_done, m_fresh;
    int m_cnt;
    int m_x, m_y, m_xm, m_ym, m_xz, m_yz;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle = 1'b1; m_done = 1'b0; m_fresh = 1'b1; m_cnt = 0;
            m_x = 0; m_y = 0; m_xm = 0; m_ym = 0; m_xz = 0; m_yz = 0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle  = 1'b0;
                m_fresh = 1'b0;
                m_cnt   = ((lz_of(n_var_1) > lz_of(n_var_2)) ?
                           lz_of(n_var_1) : lz_of(n_var_2)) + 1;
                m_x  = char_of(n_var_1);
                m_y  = char_of(n_var_2);
                m_xm = mant_of(n_var_1);
                m_ym = mant_of(n_var_2);
                m_xz = (n_var_1 == 8'd0);
                m_yz = (n_var_2 == 8'd0);
            end
        end else if (!m_done) begin
            m_cnt--;
            if (m_cnt == 0) m_done = 1'b1;
        end else if (out_ready) begin
            m_done = 1'b0;
            m_idle = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", int'(in_ready), int'(m_idle));
            chk("out_valid", int'(out_valid), int'(m_done));
            chk("busy", int'(busy), int'(!m_idle && !m_done));
            if (m_done || m_fresh) begin
                chk("x", int'(x), m_x);
                chk("y", int'(y), m_y);
                chk("xm", int'(xm), m_xm);
                chk("ym", int'(ym), m_ym);
                chk("xz", int'(xz), m_xz);
                chk("yz", int'(yz), m_yz);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        if (!in_ready) chk("wait_idle_timeout", 0, 1);
    endtask

    // Drive one pair from IDLE, measure latency and busy cycles, compare to literals.
    task automatic run_pair(input logic [7:0] a, input logic [7:0] b, input logic ordy,
                            input int ex, input int exm, input int ey, input int eym,
                            input int exz, input int eyz, input int elat, input int ebusy);
        int lat = 0;
        int bcnt = 0;
        out_ready = ordy;
        n_var_1   = a;
        n_var_2   = b;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        n_var_1   = 8'($urandom);
        n_var_2   = 8'($urandom);
        while (!out_valid && lat < 20) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
        chk("latency", lat, elat);
        if (ebusy >= 0) chk("busy_cycles", bcnt, ebusy);
        chk("lit_x", int'(x), ex);
        chk("lit_xm", int'(xm), exm);
        chk("lit_y", int'(y), ey);
        chk("lit_ym", int'(ym), eym);
        chk("lit_xz", int'(xz), exz);
        chk("lit_yz", int'(yz), eyz);
        chk("model_x", m_x, ex);
        chk("model_ym", m_ym, eym);
    endtask

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return 8'd0;
            1:       return 8'(1 << $urandom_range(0, 7));
            2:       return 8'($urandom_range(0, 15));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n_var_1   = 8'($urandom);
        n_var_2   = 8'($urandom);
        @(posedge clk);
        cmp_en = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_xz", int'(xz), 0);
        step();
        in_valid = 1'b0;
        rst      = 1'b0;
        step();
        chk("post_rst_in_ready", int'(in_ready), 1);

        wait_idle();
        run_pair(8'h80, 8'h01, 1'b1, 7, 8'h00, 0, 8'h00, 0, 0, 8, 8);
        wait_idle();
        run_pair(8'hB4, 8'h0D, 1'b1, 7, 8'h34, 3, 8'h50, 0, 0, 5, 5);
        wait_idle();
        run_pair(8'h00, 8'hFF, 1'b1, 0, 8'h00, 7, 8'h7F, 1, 0, 1, 1);

        // Backpressure with ignored in_valid pulses.
        wait_idle();
        run_pair(8'h40, 8'h20, 1'b0, 6, 8'h00, 5, 8'h00, 0, 0, 3, 3);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            n_var_1  = 8'($urandom);
            n_var_2  = 8'($urandom);
            step();
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_x", int'(x), 6);
            chk("bp_y", int'(y), 5);
            chk("bp_xm", int'(xm), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);

        // Reset three cycles after acceptance aborts the operation.
        wait_idle();
        n_var_1  = 8'h01;
        n_var_2  = 8'h01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_busy", int'(busy), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("abort_no_valid", int'(out_valid), 0);
        end
        wait_idle();
        run_pair(8'h03, 8'h06, 1'b1, 1, 8'h40, 2, 8'h40, 0, 0, 7, -1);

        // Randomized traffic, checked every cycle by the model comparator.
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            in_valid  = ($urandom_range(0, 2) == 0);
            n_var_1   = rand_op();
            n_var_2   = rand_op();
            out_ready = ($urandom_range(0, 2) != 0);
        end
        wait_idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/log_encode_seq.md
# log_encode_seq

Sequential logarithm front end for the 8-bit logarithmic multiplier. It accepts two unsigned 8-bit operands through a valid/ready handshake and finds each operand's characteristic (floor log2) by iterative left-normalisation. It also produces each operand's Mitchell mantissa (the bits below the leading one) and a zero flag. It sits directly upstream of the antilog/adder stage, which consumes the two 4-bit characteristics (and, in the Mitchell path, the mantissas).

## Interface
- No parameters; operand width is fixed at 8, characteristic at 4, mantissa at 7.
- clk  input  1  rising-edge clock, single domain
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair on n_var_1/n_var_2 is valid
- in_ready  output  1  block can accept an operand pair (high only in IDLE)
- n_var_1  input  8  operand A, unsigned
- n_var_2  input  8  operand B, unsigned
- out_valid  output  1  result registers hold a completed pair (high only in DONE)
- out_ready  input  1  downstream accepts the result
- x  output  4  characteristic of A, range 0..7, bit 3 always 0
- y  output  4  characteristic of B, range 0..7, bit 3 always 0
- xm  output  7  mantissa of A (normalised bits [6:0])
- ym  output  7  mantissa of B
- xz  output  1  A was zero
- yz  output  1  B was zero
- busy  output  1  high in SHIFT

## Operation
- Three-state FSM: IDLE, SHIFT, DONE. Reset state is IDLE.
- Internal registers: ra, rb (8-bit working operands), ca, cb (4-bit characteristics), za, zb.
- in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==SHIFT). All three are decoded combinationally from the state register.
- IDLE: when in_valid is sampled high:
  - load ra=n_var_1, rb=n_var_2, ca=cb=7;
  - set za=(n_var_1==0), zb=(n_var_2==0);
  - go to SHIFT.
- SHIFT, evaluated per cycle for each operand independently:
  - An operand is finished if its ra[7]==1 or its z flag is set.
  - An unfinished operand shifts left by 1 (zero fill) and its characteristic decrements by 1.
  - If both operands are finished at the start of the cycle, no shift occurs and the FSM goes to DONE.
- DONE: outputs are held stable. When out_ready is sampled high, go to IDLE.
- There is no same-cycle re-accept. in_ready rises on the cycle after the handoff.
- Output mapping:
  - x=ca, y=cb, xm=ra[6:0], ym=rb[6:0], xz=za, yz=zb.
  - A zero operand reports characteristic 0 and mantissa 0. During SHIFT the characteristic register of a zero operand holds 7; outputs force it to 0.
- Outputs x/y/xm/ym/xz/yz are registered values and are valid only while out_valid=1. Their values in other states are don't-care, except at reset.
- Characteristic arithmetic: ca decrements at most 7 times, so it never wraps below 0. The decrement is unsigned 4-bit.
- in_valid while not in IDLE is ignored. Inputs are sampled only on the accepting edge; later changes on n_var_1/n_var_2 have no effect.
- out_ready outside DONE is ignored.

## Timing
- Reset (rst high, asynchronous): state=IDLE and all internal registers 0.
  - Outputs during and after reset: x=y=0, xm=ym=0, xz=yz=0, out_valid=0, busy=0, in_ready=1.
- Let lz(v) be the number of leading zeros of v, with lz(0)=0. If the pair is accepted at edge E0, out_valid goes high after edge E0+max(lz(A),lz(B))+1.
- Latency is 1 cycle minimum (both MSBs set) and 8 cycles maximum (an operand equal to 0x01).
- In DONE, results are held indefinitely under backpressure. The FSM leaves DONE on the edge where out_ready=1.
- Throughput: one pair per (latency + 2) cycles with out_ready tied high.
- rst asserted mid-SHIFT or in DONE aborts the operation immediately. The result is discarded and no out_valid pulse follows.

## Test plan
- Reset: assert rst with random inputs -> in_ready=1, out_valid=0, x=y=0, xz=yz=0. Deassert rst -> state IDLE.
- A=0x80, B=0x01, out_ready=1 -> out_valid after edge E0+8; x=7, xm=0x00, y=0, ym=0x00, xz=yz=0. busy high for exactly 8 cycles.
- A=0xB4, B=0x0D -> x=7, xm=0x34, y=3, ym=0x50. out_valid after edge E0+5.
- A=0x00, B=0xFF -> xz=1, x=0, xm=0, y=7, ym=0x7F, yz=0. out_valid after edge E0+1.
- Backpressure: A=0x40, B=0x20 with out_ready=0 for 10 cycles:
  - outputs stable at x=6, y=5, xm=ym=0 and out_valid held high;
  - in_valid pulses during this window are ignored;
  - out_ready=1 for one cycle -> IDLE, then in_ready=1 on the next cycle.
- Reset mid-operation: A=0x01, B=0x01, assert rst 3 cycles after acceptance -> immediate IDLE, no out_valid. Next pair A=0x03, B=0x06 -> x=1, xm=0x40, y=2, ym=0x40.
